bht_port_arbiter: RTL and testbench

- Owns the single port of the branch history table (BHT) SRAM: 2^TABLE_WIDTH entries, 2-bit saturating counters.
- Shares that port between two requesters:
  - Fetch-stage prediction lookups (high priority).
  - ID-stage counter updates, which are queued and applied by read-modify-write (RMW).
- Also sequences table initialisation after reset or on request.
- Sits between the IF/ID pipeline stages and the BHT SRAM macro.

---
 rtl/bht_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_bht_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_port_arbiter.sv
// BHT port arbiter: shares the single-port BHT SRAM between fetch lookups,
// queued read-modify-write counter updates and table initialisation.
module bht_port_arbiter #(
    parameter int TABLE_WIDTH  = 3,
    parameter int QUEUE_DEPTH  = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_req,
    output logic                   init_done,
    input  logic                   lk_valid,
    input  logic [TABLE_WIDTH-1:0] lk_idx,
    output logic                   lk_ready,
    output logic                   pred_valid,
    output logic                   pred_taken,
    input  logic                   upd_valid,
    input  logic [TABLE_WIDTH-1:0] upd_idx,
    input  logic                   upd_taken,
    output logic                   upd_ready,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [TABLE_WIDTH-1:0] mem_addr,
    output logic [1:0]             mem_wdata,
    input  logic [1:0]             mem_rdata
);

    localparam int ENTRIES  = 1 << TABLE_WIDTH;
    localparam int PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RD, ST_WR} state_t;

    state_t                 state_q, state_d;
    logic [TABLE_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [STARVE_W-1:0]    starve_q, starve_d;
    logic [1:0]             hold_q, hold_d;
    logic                   pred_valid_q, pred_valid_d;
    logic                   fwd_q, fwd_d;
    logic                   fwd_bit_q, fwd_bit_d;
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
    logic [TABLE_WIDTH:0]   fifo_q [QUEUE_DEPTH];
    logic [TABLE_WIDTH:0]   fifo_d [QUEUE_DEPTH];

    logic                   empty, full, push, pop;
    logic [TABLE_WIDTH:0]   head;
    logic [TABLE_WIDTH-1:0] head_idx;
    logic                   head_taken;
    logic                   rmw_active, force_wr, lk_accept;
    logic [1:0]             rmw_new;
    logic                   mem_en_c, mem_we_c;
    logic [TABLE_WIDTH-1:0] mem_addr_c;
    logic [1:0]             mem_wdata_c;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign head_idx   = head[TABLE_WIDTH:1];
    assign head_taken = head[0];

    assign rmw_active = (state_q == ST_RD) || (state_q == ST_WR);
    assign force_wr   = (state_q == ST_WR) && (starve_q == STARVE_W'(STARVE_LIMIT));
    assign init_done  = (state_q != ST_INIT);
    assign lk_ready   = init_done && !force_wr;
    assign lk_accept  = lk_valid && lk_ready;
    assign upd_ready  = init_done && !full;
    assign push       = upd_valid && upd_ready;

    // In RD the read data belongs to the RMW; in WR the computed value was parked in hold_q.
    assign rmw_new    = (state_q == ST_RD) ? sat_update(mem_rdata, head_taken) : hold_q;

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_valid_q && (fwd_q ? fwd_bit_q : mem_rdata[1]);

    assign mem_en     = mem_en_c && !rst;
    assign mem_we     = mem_we_c && !rst;
    assign mem_addr   = mem_addr_c;
    assign mem_wdata  = mem_wdata_c;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        starve_d     = starve_q;
        hold_d       = hold_q;
        pred_valid_d = 1'b0;
        fwd_d        = 1'b0;
        fwd_bit_d    = 1'b0;
        pop          = 1'b0;
        mem_en_c     = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = 2'b00;

        if (lk_accept) begin
            mem_en_c     = 1'b1;
            mem_addr_c   = lk_idx;
            pred_valid_d = !init_req;
            fwd_d        = rmw_active && (lk_idx == head_idx);
            fwd_bit_d    = rmw_new[1];
        end

        case (state_q)
            ST_INIT: begin
                mem_en_c    = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = init_cnt_q;
                mem_wdata_c = 2'b01;
                init_cnt_d  = init_cnt_q + TABLE_WIDTH'(1);
                if (init_cnt_q == TABLE_WIDTH'(ENTRIES - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!lk_accept && !empty) begin
                    mem_en_c   = 1'b1;
                    mem_addr_c = head_idx;
                    state_d    = ST_RD;
                end
            end
            ST_RD, ST_WR: begin
                if (lk_accept) begin
                    hold_d  = rmw_new;
                    state_d = ST_WR;
                    if (state_q == ST_WR) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else begin
                    mem_en_c    = 1'b1;
                    mem_we_c    = 1'b1;
                    mem_addr_c  = head_idx;
                    mem_wdata_c = rmw_new;
                    pop         = 1'b1;
                    starve_d    = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Re-init drops any RMW port use this cycle; an accepted lookup still reads but is never reported.
        if (init_req) begin
            state_d    = ST_INIT;
            init_cnt_d = '0;
            starve_d   = '0;
            pop        = 1'b0;
            if (!lk_accept) begin
                mem_en_c    = 1'b0;
                mem_we_c    = 1'b0;
                mem_addr_c  = '0;
                mem_wdata_c = 2'b00;
            end
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q[PTR_W-1:0]] = {upd_idx, upd_taken};
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
        if (init_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            starve_q     <= '0;
            hold_q       <= 2'b00;
            pred_valid_q <= 1'b0;
            fwd_q        <= 1'b0;
            fwd_bit_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            starve_q     <= starve_d;
            hold_q       <= hold_d;
            pred_valid_q <= pred_valid_d;
            fwd_q        <= fwd_d;
            fwd_bit_q    <= fwd_bit_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_q       <= fifo_d;
        end
    end

endmodule

// File: tb/tb_bht_port_arbiter.sv
// Testbench for bht_port_arbiter: SRAM model, table-level reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_bht_port_arbiter;

    localparam int TW = 3;
    localparam int QD = 4;
    localparam int SL = 4;
    localparam int N  = 1 << TW;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          init_req  = 1'b0;
    logic          lk_valid  = 1'b0;
    logic [TW-1:0] lk_idx    = '0;
    logic          upd_valid = 1'b0;
    logic [TW-1:0] upd_idx   = '0;
    logic          upd_taken = 1'b0;
    logic          init_done, lk_ready, pred_valid, pred_taken, upd_ready;
    logic          mem_en, mem_we;
    logic [TW-1:0] mem_addr;
    logic [1:0]    mem_wdata;
    logic [1:0]    mem_rdata = 2'b00;

    logic [1:0]    sram [N];
    int            n_cmp  = 0;
    int            n_fail = 0;

    // Reference model state: expected table contents plus pending update queue.
    logic          m_init;
    int            m_cnt, m_phase, m_starve;
    logic [1:0]    m_tbl [N];
    logic [TW:0]   m_q [$];
    logic          e_pv, e_pt;

    always #5 clk = ~clk;

    bht_port_arbiter #(.TABLE_WIDTH(TW), .QUEUE_DEPTH(QD), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .init_done(init_done),
        .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_ready(lk_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) sram[i] <= 2'b11;
        end else if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return v[1:0];
    endfunction

    always @(negedge clk) begin : model
        logic          done, force_wr, acc, push, fwd, e_en, e_we, h_t;
        logic [TW-1:0] e_addr, h_idx;
        logic [1:0]    e_wd, nv;
        if (rst) begin
            check_output("rst_init_done", init_done, 0);
            check_output("rst_lk_ready", lk_ready, 0);
            check_output("rst_upd_ready", upd_ready, 0);
            check_output("rst_pred_valid", pred_valid, 0);
            check_output("rst_mem_en", mem_en, 0);
            check_output("rst_mem_we", mem_we, 0);
            m_init = 1'b1; m_cnt = 0; m_phase = 0; m_starve = 0;
            m_q.delete();
            e_pv = 1'b0; e_pt = 1'b0;
        end else begin
            done     = !m_init;
            force_wr = (m_phase == 2) && (m_starve == SL);
            acc      = lk_valid && done && !force_wr;
            push     = upd_valid && done && (m_q.size() < QD);
            h_idx = '0; h_t = 1'b0; nv = 2'b00;
            if (m_q.size() > 0) begin
                h_idx = m_q[0][TW:1];
                h_t   = m_q[0][0];
                nv    = sat(m_tbl[h_idx], h_t);
            end
            check_output("init_done", init_done, done);
            check_output("lk_ready", lk_ready, done && !force_wr);
            check_output("upd_ready", upd_ready, done && (m_q.size() < QD));
            check_output("pred_valid", pred_valid, e_pv);
            check_output("pred_taken", pred_taken, e_pt);

            e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = 2'b00;
            if (acc) begin
                e_en = 1'b1; e_addr = lk_idx;
            end else if (init_req) begin
                e_en = 1'b0;
            end else if (m_init) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = TW'(m_cnt); e_wd = 2'b01;
            end else if (m_phase == 0 && m_q.size() > 0) begin
                e_en = 1'b1; e_addr = h_idx;
            end else if (m_phase != 0) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = h_idx; e_wd = nv;
            end
            check_output("mem_en", mem_en, e_en);
            if (e_en) begin
                check_output("mem_we", mem_we, e_we);
                check_output("mem_addr", mem_addr, e_addr);
                if (e_we) check_output("mem_wdata", mem_wdata, e_wd);
            end

            fwd = acc && (m_phase != 0) && (lk_idx == h_idx);
            if (init_req) begin
                m_init = 1'b1; m_cnt = 0; m_phase = 0; m_starve = 0;
                m_q.delete();
                e_pv = 1'b0; e_pt = 1'b0;
            end else begin
                e_pv = acc;
                e_pt = acc ? (fwd ? nv[1] : m_tbl[lk_idx][1]) : 1'b0;
                if (m_init) begin
                    m_tbl[m_cnt] = 2'b01;
                    if (m_cnt == N - 1) m_init = 1'b0;
                    m_cnt = (m_cnt + 1) % N;
                end else if (acc) begin
                    if (m_phase == 1) m_phase = 2;
                    else if (m_phase == 2) m_starve++;
                end else if (m_phase == 0 && m_q.size() > 0) begin
                    m_phase = 1;
                end else if (m_phase != 0) begin
                    m_tbl[h_idx] = nv;
                    void'(m_q.pop_front());
                    m_phase = 0;
                    m_starve = 0;
                end
                if (push) m_q.push_back({upd_idx, upd_taken});
            end
        end
    end

    task automatic apply_stimulus(input logic lv, input logic [TW-1:0] li, input logic uv,
                                  input logic [TW-1:0] ui, input logic ut, input logic ir);
        @(posedge clk);
        #1;
        lk_valid = lv; lk_idx = li; upd_valid = uv; upd_idx = ui; upd_taken = ut; init_req = ir;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_init(input string name);
        int cnt;
        bit seen;
        cnt = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (init_done) seen = 1;
            else cnt++;
        end
        check_output(name, seen ? cnt : -1, N);
    endtask

    task automatic lookup_expect(input logic [TW-1:0] idx, input logic exp_taken, input string name);
        apply_stimulus(1, idx, 0, 0, 0, 0);
        @(negedge clk);
        check_output({name, "_accept"}, lk_ready, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output({name, "_pv"}, pred_valid, 1);
        check_output({name, "_pt"}, pred_taken, exp_taken);
    endtask

    task automatic push_update(input logic [TW-1:0] idx, input logic t);
        apply_stimulus(0, 0, 1, idx, t, 0);
        idle(4);
    endtask

    initial begin
        int           lows;
        logic         rdy [5];
        logic [TW-1:0] fidx [5];
        fidx[0] = 1; fidx[1] = 1; fidx[2] = 4; fidx[3] = 4; fidx[4] = 7;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_init("init_cycles");
        lookup_expect(5, 0, "lk5_after_init");

        // Saturation at index 2 in both directions.
        for (int i = 0; i < 3; i++) push_update(2, 1);
        check_output("sat_up_sram2", sram[2], 2'b11);
        lookup_expect(2, 1, "lk2_sat_up");
        for (int i = 0; i < 4; i++) push_update(2, 0);
        check_output("sat_dn_sram2", sram[2], 2'b00);
        lookup_expect(2, 0, "lk2_sat_dn");

        // Lookup during RD of an update to the same index sees the new counter.
        check_output("fwd_pre_sram3", sram[3], 2'b01);
        apply_stimulus(0, 0, 1, 3, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 3, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("fwd_pv", pred_valid, 1);
        check_output("fwd_pt", pred_taken, 1);
        idle(2);
        check_output("fwd_sram3", sram[3], 2'b10);

        // Continuous lookups starve the pending write until the limit forces it.
        apply_stimulus(0, 0, 1, 6, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (!lk_ready) lows++;
        end
        idle(2);
        check_output("starve_lk_ready_lows", lows, 1);
        check_output("starve_sram6", sram[6], 2'b10);

        // Fill the FIFO while lookups own the port.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 0, 1, fidx[i], 1, 0);
            @(negedge clk);
            rdy[i] = upd_ready;
        end
        check_output("full_first_ready", rdy[0], 1);
        check_output("full_fourth_ready", rdy[3], 1);
        check_output("full_fifth_ready", rdy[4], 0);
        idle(20);
        check_output("full_sram1", sram[1], 2'b11);
        check_output("full_sram4", sram[4], 2'b11);
        check_output("full_sram7", sram[7], 2'b01);

        // Re-init during RD: the RMW write must be dropped and the table rewritten.
        apply_stimulus(0, 0, 1, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check_output("reinit_no_write", mem_en, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        wait_init("reinit_cycles");
        for (int i = 0; i < N; i++) check_output($sformatf("reinit_sram%0d", i), sram[i], 2'b01);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), TW'($urandom_range(0, N - 1)),
                           $urandom_range(0, 9) < 4, TW'($urandom_range(0, N - 1)),
                           1'($urandom_range(0, 1)), $urandom_range(0, 299) == 0);
        end
        idle(30);
        for (int i = 0; i < N; i++) check_output($sformatf("final_sram%0d", i), sram[i], m_tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
